fft_mag_calc: RTL and testbench



---
 rtl/fft_disp_pkg.sv | 28 ++
 rtl/fft_isqrt_pipe.sv | 75 +++++++
 rtl/fft_mag_calc.sv | 135 +++++++++++++
 tb/tb_fft_mag_calc.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/fft_disp_pkg.sv
// Shared constants, sideband tag type and pseudo-log helper for the FFT magnitude and display path.
package fft_disp_pkg;

    localparam int FFT_POINTS = 1024;
    localparam int OUT_POINTS = 512;
    localparam int MAG_W      = 9;
    localparam int MAG_LAT    = 21;
    localparam int ROOT_W     = 17;

    typedef struct packed {
        logic valid;
        logic eop;
    } tag_t;

    // {MSB index, 4 bits below the MSB}. Normalising the root first makes e<4 pad with zeros for free.
    function automatic logic [MAG_W-1:0] log_mag(input logic [ROOT_W-1:0] root);
        logic [4:0]        e;
        logic [ROOT_W-1:0] norm;
        e = '0;
        for (int i = 0; i < ROOT_W; i++) begin
            if (root[i]) e = 5'(i);
        end
        norm = root << (ROOT_W - 1 - int'(e));
        if (root == '0) return '0;
        return {e, norm[ROOT_W-2 -: 4]};
    endfunction

endpackage

// File: rtl/fft_isqrt_pipe.sv
// Restoring integer square root, one root bit per pipeline stage (MSB first), with {valid, eop} sideband.
module fft_isqrt_pipe
    import fft_disp_pkg::*;
#(
    parameter int RAD_W = 33,
    parameter int RT_W  = (RAD_W + 1) / 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [RAD_W-1:0]  rad,
    input  tag_t              rad_tag,
    output logic [RT_W-1:0]   root,
    output tag_t              root_tag
);

    localparam int PAD_W = 2 * RT_W;
    localparam int REM_W = RT_W + 2;

    logic [PAD_W-1:0] rad_pipe [0:RT_W-1];
    logic [REM_W-1:0] rem_pipe [0:RT_W-1];
    logic [RT_W-1:0]  q_pipe   [0:RT_W-1];
    tag_t             tag_pipe [0:RT_W-1];

    for (genvar gi = 0; gi < RT_W; gi++) begin : g_stage
        logic [PAD_W-1:0] cur_rad;
        logic [REM_W-1:0] cur_rem;
        logic [RT_W-1:0]  cur_q;
        tag_t             cur_tag;
        logic [REM_W+1:0] rem_sh;
        logic [REM_W+1:0] trial;

        if (gi == 0) begin : g_head
            assign cur_rad = PAD_W'(rad);
            assign cur_rem = '0;
            assign cur_q   = '0;
            assign cur_tag = rad_tag;
        end else begin : g_body
            assign cur_rad = rad_pipe[gi-1];
            assign cur_rem = rem_pipe[gi-1];
            assign cur_q   = q_pipe[gi-1];
            assign cur_tag = tag_pipe[gi-1];
        end

        // Bring down the next radicand bit pair and try appending a 1 to the partial root.
        assign rem_sh = {cur_rem, cur_rad[PAD_W-1 -: 2]};
        assign trial  = {2'b00, cur_q, 2'b01};

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rad_pipe[gi] <= '0;
                rem_pipe[gi] <= '0;
                q_pipe[gi]   <= '0;
                tag_pipe[gi] <= '0;
            end else begin
                rad_pipe[gi] <= cur_rad << 2;
                tag_pipe[gi] <= cur_tag;
                if (rem_sh >= trial) begin
                    rem_pipe[gi] <= REM_W'(rem_sh - trial);
                    q_pipe[gi]   <= {cur_q[RT_W-2:0], 1'b1};
                end else begin
                    rem_pipe[gi] <= REM_W'(rem_sh);
                    q_pipe[gi]   <= {cur_q[RT_W-2:0], 1'b0};
                end
            end
        end
    end

    // Final remainder and exhausted radicand are not needed downstream.
    logic unused_tail;
    assign unused_tail = ^{rad_pipe[RT_W-1], rem_pipe[RT_W-1]};

    assign root     = q_pipe[RT_W-1];
    assign root_tag = tag_pipe[RT_W-1];

endmodule

// File: rtl/fft_mag_calc.sv
// Streaming FFT bin magnitude sqrt(re^2+im^2), first OUT_POINTS bins per frame, scaled to 9 bits.
// Define FFT_MAG_LOG_EN to output a pseudo-log2 magnitude instead of the linear shifted value.
module fft_mag_calc
    import fft_disp_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int FFT_POINTS = fft_disp_pkg::FFT_POINTS,
    parameter int OUT_POINTS = fft_disp_pkg::OUT_POINTS,
    parameter int SHIFT      = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [DATA_W-1:0] src_re,
    input  logic signed [DATA_W-1:0] src_im,
    input  logic                     src_valid,
    input  logic                     src_sop,
    input  logic                     src_eop,
    output logic [MAG_W-1:0]         fft_data,
    output logic                     fft_valid,
    output logic                     fft_eop
);

    localparam int BIN_W = $clog2(FFT_POINTS);
    localparam int SQ_W  = 2 * DATA_W;
    localparam int SUM_W = SQ_W + 1;
    localparam int RT_W  = (SUM_W + 1) / 2;
    localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(OUT_POINTS - 1);

    logic              in_frame_reg;
    logic [BIN_W-1:0]  bin_cnt_reg;
    logic              beat_active;
    logic [BIN_W-1:0]  bin_next;
    tag_t              s1_tag_next;
    logic [DATA_W-1:0] a_next;
    logic [DATA_W-1:0] b_next;

    logic [DATA_W-1:0] a_reg;
    logic [DATA_W-1:0] b_reg;
    tag_t              s1_tag_reg;
    logic [SQ_W-1:0]   sq_a_reg;
    logic [SQ_W-1:0]   sq_b_reg;
    tag_t              s2_tag_reg;
    logic [SUM_W-1:0]  sum_reg;
    tag_t              s3_tag_reg;

    logic [RT_W-1:0]   root;
    tag_t              root_tag;
    logic [MAG_W-1:0]  mag_next;

    // sop always (re)starts a frame; other beats only count while a frame is open.
    always_comb begin
        beat_active = 1'b0;
        bin_next    = bin_cnt_reg;
        if (src_valid && src_sop) begin
            beat_active = 1'b1;
            bin_next    = '0;
        end else if (src_valid && in_frame_reg) begin
            beat_active = 1'b1;
            bin_next    = bin_cnt_reg + 1'b1;
        end
        s1_tag_next       = '0;
        s1_tag_next.valid = beat_active && (bin_next <= LAST_BIN);
        s1_tag_next.eop   = beat_active && (bin_next == LAST_BIN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_frame_reg <= 1'b0;
            bin_cnt_reg  <= '0;
        end else if (beat_active) begin
            in_frame_reg <= ~src_eop;
            bin_cnt_reg  <= bin_next;
        end
    end

    // Two's-complement negate; the most negative input yields 2^(DATA_W-1) as unsigned.
    assign a_next = src_re[DATA_W-1] ? (~src_re + 1'b1) : src_re;
    assign b_next = src_im[DATA_W-1] ? (~src_im + 1'b1) : src_im;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg      <= '0;
            b_reg      <= '0;
            s1_tag_reg <= '0;
            sq_a_reg   <= '0;
            sq_b_reg   <= '0;
            s2_tag_reg <= '0;
            sum_reg    <= '0;
            s3_tag_reg <= '0;
        end else begin
            a_reg      <= a_next;
            b_reg      <= b_next;
            s1_tag_reg <= s1_tag_next;
            sq_a_reg   <= SQ_W'(a_reg) * SQ_W'(a_reg);
            sq_b_reg   <= SQ_W'(b_reg) * SQ_W'(b_reg);
            s2_tag_reg <= s1_tag_reg;
            sum_reg    <= SUM_W'(sq_a_reg) + SUM_W'(sq_b_reg);
            s3_tag_reg <= s2_tag_reg;
        end
    end

    fft_isqrt_pipe #(
        .RAD_W (SUM_W)
    ) u_isqrt (
        .clk      (clk),
        .rst      (rst),
        .rad      (sum_reg),
        .rad_tag  (s3_tag_reg),
        .root     (root),
        .root_tag (root_tag)
    );

`ifdef FFT_MAG_LOG_EN
    assign mag_next = log_mag(ROOT_W'(root));
`else
    logic [RT_W-1:0] scaled;
    assign scaled   = root >> SHIFT;
    assign mag_next = (|scaled[RT_W-1:MAG_W]) ? '1 : scaled[MAG_W-1:0];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fft_data  <= '0;
            fft_valid <= 1'b0;
            fft_eop   <= 1'b0;
        end else begin
            fft_valid <= root_tag.valid;
            fft_eop   <= root_tag.valid & root_tag.eop;
            if (root_tag.valid) begin
                fft_data <= mag_next;
            end
        end
    end

endmodule

// File: tb/tb_fft_mag_calc.sv
// Random/directed frames into three SHIFT variants, checked cycle by cycle against an arithmetic reference model.
module tb_fft_mag_calc;

    logic               clk = 1'b0;
    logic               rst;
    logic signed [15:0] src_re;
    logic signed [15:0] src_im;
    logic               src_valid;
    logic               src_sop;
    logic               src_eop;

    logic [8:0] d6, d0, d7;
    logic       v6, v0, v7;
    logic       e6, e0, e7;

    always #5 clk = ~clk;

    fft_mag_calc #(.DATA_W(16), .FFT_POINTS(1024), .OUT_POINTS(512), .SHIFT(6)) dut (
        .clk(clk), .rst(rst), .src_re(src_re), .src_im(src_im), .src_valid(src_valid),
        .src_sop(src_sop), .src_eop(src_eop), .fft_data(d6), .fft_valid(v6), .fft_eop(e6));

    fft_mag_calc #(.DATA_W(16), .FFT_POINTS(1024), .OUT_POINTS(512), .SHIFT(0)) dut_s0 (
        .clk(clk), .rst(rst), .src_re(src_re), .src_im(src_im), .src_valid(src_valid),
        .src_sop(src_sop), .src_eop(src_eop), .fft_data(d0), .fft_valid(v0), .fft_eop(e0));

    fft_mag_calc #(.DATA_W(16), .FFT_POINTS(1024), .OUT_POINTS(512), .SHIFT(7)) dut_s7 (
        .clk(clk), .rst(rst), .src_re(src_re), .src_im(src_im), .src_valid(src_valid),
        .src_sop(src_sop), .src_eop(src_eop), .fft_data(d7), .fft_valid(v7), .fft_eop(e7));

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int due;
        int d [3];
        bit eop;
    } exp_t;

    exp_t q[$];
    int   last_d [3];
    bit   m_in_frame;
    int   m_bin;

    function automatic int sh_of(int i);
        return (i == 0) ? 6 : ((i == 1) ? 0 : 7);
    endfunction

    function automatic int isqrt(longint s);
        longint r;
        r = longint'($sqrt(real'(s)));
        while (r * r > s) r--;
        while ((r + 1) * (r + 1) <= s) r++;
        return int'(r);
    endfunction

    function automatic int expect_out(int root, int sh);
`ifdef FFT_MAG_LOG_EN
        int e;
        int m;
        if (root == 0) return 0;
        e = 0;
        while ((root >> (e + 1)) != 0) e++;
        m = (e >= 4) ? ((root >> (e - 4)) & 15) : ((root << (4 - e)) & 15);
        return e * 16 + m;
`else
        int v;
        v = root >> sh;
        return (v > 511) ? 511 : v;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("FAIL %s at cycle %0d: observed=%0d expected=%0d", tag, cyc, observed, expected);
        end
    endtask

    task automatic check_inst(input string nm, input logic v, input logic e, input logic [8:0] d,
                              input bit ev, input bit eeop, input int ld);
        chk({nm, "_valid"}, 32'(v), 32'(ev));
        chk({nm, "_eop"},   32'(e), 32'(eeop));
        chk({nm, "_data"},  32'(d), 32'(ld));
    endtask

    // Every cycle: the model says whether a kept bin is due now; otherwise valid/eop low and data held.
    always @(negedge clk) begin
        bit   ev;
        exp_t e;
        #1;
        ev = (q.size() > 0) && (q[0].due == cyc);
        e.eop = 1'b0;
        if (ev) begin
            e = q.pop_front();
            for (int i = 0; i < 3; i++) last_d[i] = e.d[i];
        end
        check_inst("s6", v6, e6, d6, ev, ev && e.eop, last_d[0]);
        check_inst("s0", v0, e0, d0, ev, ev && e.eop, last_d[1]);
        check_inst("s7", v7, e7, d7, ev, ev && e.eop, last_d[2]);
    end

    task automatic beat(input logic signed [15:0] re, input logic signed [15:0] im, input bit sop, input bit eop);
        exp_t   e;
        bit     act;
        longint s;
        int     root;
        @(negedge clk);
        src_valid = 1'b1;
        src_re    = re;
        src_im    = im;
        src_sop   = sop;
        src_eop   = eop;
        act = 1'b0;
        if (sop) begin
            m_bin = 0;
            act   = 1'b1;
        end else if (m_in_frame) begin
            m_bin++;
            act = 1'b1;
        end
        if (act) begin
            m_in_frame = !eop;
            if (m_bin < 512) begin
                s    = longint'(re) * longint'(re) + longint'(im) * longint'(im);
                root = isqrt(s);
                e.due = cyc + 21;
                for (int i = 0; i < 3; i++) e.d[i] = expect_out(root, sh_of(i));
                e.eop = (m_bin == 511);
                q.push_back(e);
            end
        end
        $display("beat cyc=%0d re=%0d im=%0d sop=%0b eop=%0b bin=%0d kept=%0b",
                 cyc, re, im, sop, eop, m_bin, act && (m_bin < 512));
    endtask

    task automatic gap();
        @(negedge clk);
        src_valid = 1'b0;
        src_sop   = 1'($urandom);
        src_eop   = 1'($urandom);
        src_re    = 16'($urandom);
        src_im    = 16'($urandom);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst       = 1'b1;
        src_valid = 1'b0;
        q.delete();
        for (int i = 0; i < 3; i++) last_d[i] = 0;
        m_in_frame = 1'b0;
        repeat (n) @(negedge clk);
        rst = 1'b0;
        $display("reset cyc=%0d cycles=%0d", cyc, n);
    endtask

    task automatic pattern(input int kind, input int k, output logic signed [15:0] re, output logic signed [15:0] im);
        case (kind)
            0:       begin re = 16'sd3;       im = 16'sd4;       end
            1:       begin re = -16'sd32768;  im = -16'sd32768;  end
            2:       begin re = (k < 512) ? 16'(100 * k) : 16'($urandom); im = (k < 512) ? 16'sd0 : 16'($urandom); end
            4:       begin re = 16'sd0;       im = 16'sd0;       end
            default: begin re = 16'($urandom); im = 16'($urandom); end
        endcase
    endtask

    task automatic run_frame(input int kind, input int first, input int len, input bit with_sop,
                             input bit with_eop, input bit gaps);
        logic signed [15:0] re;
        logic signed [15:0] im;
        for (int k = first; k < len; k++) begin
            if (gaps) begin
                while ($urandom_range(1) == 1) gap();
            end
            pattern(kind, k, re, im);
            beat(re, im, with_sop && (k == first), with_eop && (k == len - 1));
        end
    endtask

    initial begin
        rst       = 1'b1;
        src_valid = 1'b0;
        src_sop   = 1'b0;
        src_eop   = 1'b0;
        src_re    = '0;
        src_im    = '0;
        m_in_frame = 1'b0;
        m_bin      = 0;
        for (int i = 0; i < 3; i++) last_d[i] = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) gap();

        // Constant 3+4j frame, immediately followed by a full-scale frame (back-to-back).
        run_frame(0, 0, 1024, 1, 1, 0);
        run_frame(1, 0, 1024, 1, 1, 0);
        repeat (5) gap();

        // Ramp on re with random valid gaps.
        run_frame(2, 0, 1024, 1, 1, 1);
        repeat (5) gap();

        // Frame aborted by a new sop at bin 300, then a full random frame.
        run_frame(3, 0, 300, 1, 0, 0);
        run_frame(3, 0, 1024, 1, 1, 0);
        repeat (5) gap();

        // Reset at bin 200; the rest of the frame must be ignored until the next sop.
        run_frame(3, 0, 200, 1, 0, 0);
        do_reset(3);
        run_frame(3, 200, 1024, 0, 1, 0);
        repeat (5) gap();
        run_frame(3, 0, 1024, 1, 1, 1);

        // Short frame, stray beats outside any frame, a zero frame, then a full-scale frame.
        run_frame(3, 0, 100, 1, 1, 0);
        run_frame(3, 0, 20, 0, 0, 1);
        run_frame(4, 0, 30, 1, 1, 0);
        run_frame(1, 0, 1024, 1, 1, 1);

        repeat (30) gap();
        chk("drained", 32'(q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
